// File: rtl/int_stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered 32-bit valid/ready stream
// between NUM_REQ producers, with bounded burst locking and source tagging.
module int_stream_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int BURST   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    in_valid,
    input  logic [NUM_REQ*32-1:0] in_data,
    output logic [NUM_REQ-1:0]    in_ready,
    output logic                  out_valid,
    output logic [31:0]           out_data,
    output logic [ID_W-1:0]       out_id,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [7:0]      BURST_LAST = 8'(BURST - 1);
    localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(NUM_REQ - 1);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] pick;
    logic            pick_ok;
    logic [7:0]      burst_cnt;
    logic            sel_valid;
    logic [31:0]     sel_data;
    logic            can_load;
    logic            xfer;
    logic            last_beat;

    assign can_load  = !out_valid || out_ready;
    assign xfer      = (state == LOCKED) && sel_valid && can_load;
    assign last_beat = (burst_cnt == BURST_LAST);

    // Route the granted requester's valid and data onto the shared path
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_valid = in_valid[i];
                sel_data  = in_data[32*i +: 32];
            end
        end
    end

    // Find the first valid requester after the previous owner, wrapping
    always_comb begin
        logic [ID_W-1:0] idx;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!pick_ok && in_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Lock on a pick; release on a dropped valid or the final burst beat
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_ok) state_nxt = LOCKED;
            LOCKED:  if (!sel_valid || (xfer && last_beat)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Only the owner may push, and only when the output register frees up
    always_comb begin
        in_ready = '0;
        busy     = (state == LOCKED);
        if (rstn && state == LOCKED && can_load) in_ready[grant] = 1'b1;
    end

    // Grant, rotation pointer and beat counter bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant      <= '0;
            last_grant <= LAST_IDX;
            burst_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (!sel_valid) begin
                        last_grant <= grant;
                    end else if (xfer) begin
                        if (last_beat) last_grant <= grant;
                        else           burst_cnt  <= burst_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single output register: load on transfer, drain when accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_id    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_int_stream_rr_arbiter.sv
// Testbench for int_stream_rr_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_int_stream_rr_arbiter;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int BURST = 4;
    localparam int BOUND = (N - 1) * (BURST + 1) + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    in_valid;
    logic [N*32-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [31:0]     out_data;
    logic [ID_W-1:0] out_id;
    logic            out_ready;
    logic            busy;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] en;
    logic [31:0]  word [N];
    logic         out_rdy;
    logic [31:0]  cap_d [$];
    int           cap_id [$];
    logic [N-1:0] rdy_hist [$];

    int_stream_rr_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .BURST(BURST)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic drive();
        in_valid = en;
        for (int i = 0; i < N; i++) in_data[32*i +: 32] = word[i];
        out_ready = out_rdy;
    endtask

    // One clock: record handshakes, advance producers that transferred
    task automatic step();
        logic [N-1:0] xf;
        #1;
        xf = in_valid & in_ready;
        rdy_hist.push_back(in_ready);
        if (out_valid && out_ready) begin
            cap_d.push_back(out_data);
            cap_id.push_back(int'(out_id));
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) if (xf[i]) word[i] = word[i] + 32'd1;
        drive();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        en = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) word[i] = '0;
        drive();
        cap_d.delete();
        cap_id.delete();
        rdy_hist.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic check_caps(string nm, int base, int n, int ids[$], int vals[$]);
        total++;
        if (cap_d.size() < n) begin
            bad++;
            $display("FAIL %s_count: got %0d want >= %0d", nm, cap_d.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                total++;
                if (cap_id[k] !== ids[k] || cap_d[k] !== 32'(vals[k])) begin
                    bad++;
                    $display("FAIL %s[%0d]: got id=%0d data=%0d want id=%0d data=%0d",
                             nm, k + base, cap_id[k], cap_d[k], ids[k], vals[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({out_valid, busy, in_ready, out_data, out_id} !== '0) begin
            bad++;
            $display("FAIL reset_state: got v=%0b busy=%0b rdy=%b d=%0d id=%0d want all 0",
                     out_valid, busy, in_ready, out_data, out_id);
        end
    endtask

    task automatic test_single();
        int ids[$];
        int vals[$];
        do_reset();
        word[2] = 32'd10;
        en = 4'b0100;
        drive();
        repeat (11) step();
        for (int k = 0; k < 8; k++) begin
            ids.push_back(2);
            vals.push_back(10 + k);
        end
        check_caps("single", 0, 8, ids, vals);
        for (int k = 0; k < 10; k++) begin
            total++;
            if (rdy_hist[k][2] !== (k % 5 != 0)) begin
                bad++;
                $display("FAIL single_ready[%0d]: got %0b want %0b",
                         k, rdy_hist[k][2], (k % 5 != 0));
            end
        end
    endtask

    task automatic test_all_four();
        int ids[$];
        int vals[$];
        do_reset();
        for (int i = 0; i < N; i++) word[i] = 32'(i * 100);
        en = '1;
        drive();
        repeat (27) step();
        for (int k = 0; k < 20; k++) begin
            ids.push_back((k / 4) % 4);
            vals.push_back(((k / 4) % 4) * 100 + (k / 16) * 4 + k % 4);
        end
        check_caps("rr", 0, 20, ids, vals);
    endtask

    task automatic test_backpressure();
        int ids[$];
        int vals[$];
        do_reset();
        word[1] = 32'd500;
        en = 4'b0010;
        drive();
        for (int k = 0; k < 10 && !out_valid; k++) step();
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_first: got out_valid=%0b want 1", out_valid);
        end
        out_rdy = 1'b0;
        drive();
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'd500 || in_ready[1] !== 1'b0
                || busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%0b d=%0d rdy=%0b busy=%0b want 1 500 0 1",
                         k, out_valid, out_data, in_ready[1], busy);
            end
        end
        out_rdy = 1'b1;
        drive();
        repeat (8) step();
        for (int k = 0; k < 4; k++) begin
            ids.push_back(1);
            vals.push_back(500 + k);
        end
        check_caps("bp", 0, 4, ids, vals);
    endtask

    task automatic test_early_drop();
        int ids[$];
        int vals[$];
        do_reset();
        word[3] = 32'd300;
        en = 4'b1001;
        drive();
        for (int k = 0; k < 20 && word[0] != 32'd2; k++) step();
        total++;
        if (word[0] !== 32'd2) begin
            bad++;
            $display("FAIL drop_sent: got %0d want 2", word[0]);
        end
        en[0] = 1'b0;
        drive();
        repeat (10) step();
        ids = '{0, 0, 3, 3, 3, 3};
        vals = '{0, 1, 300, 301, 302, 303};
        check_caps("drop", 0, 6, ids, vals);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        word[2] = 32'd700;
        en = 4'b0100;
        out_rdy = 1'b0;
        drive();
        repeat (3) step();
        #1;
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre: got v=%0b busy=%0b want 1 1", out_valid, busy);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_async: got v=%0b rdy=%b busy=%0b want 0 0 0",
                     out_valid, in_ready, busy);
        end
        en = '1;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) word[i] = 32'(i * 10);
        drive();
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_held: got rdy=%b busy=%0b want 0 0", in_ready, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        cap_d.delete();
        cap_id.delete();
        repeat (8) step();
        total++;
        if (cap_id.size() == 0 || cap_id[0] !== 0 || cap_d[0] !== 32'd0) begin
            bad++;
            $display("FAIL mid_regrant: got n=%0d id=%0d want id 0 data 0",
                     cap_id.size(), cap_id.size() ? cap_id[0] : -1);
        end
    endtask

    task automatic test_random();
        int          m_owner, m_last, m_cnt, m_oid;
        logic        m_ov;
        logic [31:0] m_od;
        logic [31:0] q [N][$];
        longint      sum_in, sum_out;
        int          waitc [N];
        int          maxw;
        logic [N-1:0] exp_rdy;
        logic        can, found;
        logic [31:0] got;
        do_reset();
        for (int i = 0; i < N; i++) begin
            word[i] = $urandom;
            waitc[i] = 0;
        end
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_oid = 0;
        m_ov = 1'b0; m_od = '0;
        sum_in = 0; sum_out = 0; maxw = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            total++;
            if (out_valid !== m_ov || busy !== (m_owner >= 0)
                || (m_ov && (out_data !== m_od || out_id !== ID_W'(m_oid)))) begin
                bad++;
                $display("FAIL rnd_out@%0d: got v=%0b b=%0b d=%h id=%0d want v=%0b b=%0b d=%h id=%0d",
                         cyc, out_valid, busy, out_data, out_id, m_ov, (m_owner >= 0), m_od, m_oid);
            end
            for (int i = 0; i < N; i++)
                en[i] = en[i] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            out_rdy = ($urandom_range(0, 3) != 0);
            if (cyc >= 9970) begin
                en = '0;
                out_rdy = 1'b1;
            end
            drive();
            #1;
            can = !m_ov || out_rdy;
            exp_rdy = (m_owner >= 0 && can) ? (N'(1) << m_owner) : '0;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            total++;
            if ($countones(in_ready) > 1) begin
                bad++;
                $display("FAIL rnd_onehot@%0d: got %b want at most one bit", cyc, in_ready);
            end
            if (out_valid && out_ready) begin
                total++;
                if (q[out_id].size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra@%0d: got id=%0d data=%h want nothing", cyc, out_id, out_data);
                end else begin
                    got = q[out_id].pop_front();
                    if (got !== out_data) begin
                        bad++;
                        $display("FAIL rnd_order@%0d: got %h want %h", cyc, out_data, got);
                    end
                end
                sum_out += longint'(out_data);
            end
            for (int i = 0; i < N; i++) begin
                if (en[i] && m_owner != i) begin
                    if (out_rdy) waitc[i]++;
                end else begin
                    waitc[i] = 0;
                end
                if (waitc[i] > maxw) maxw = waitc[i];
            end
            if (m_owner < 0) begin
                if (m_ov && out_rdy) m_ov = 1'b0;
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && en[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        found = 1'b1;
                    end
                end
                m_cnt = 0;
            end else if (!en[m_owner]) begin
                m_last = m_owner;
                m_owner = -1;
                if (out_rdy) m_ov = 1'b0;
            end else if (can) begin
                m_ov = 1'b1;
                m_od = word[m_owner];
                m_oid = m_owner;
                if (m_cnt == BURST - 1) begin
                    m_last = m_owner;
                    m_owner = -1;
                end else begin
                    m_cnt++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    q[i].push_back(word[i]);
                    sum_in += longint'(word[i]);
                    word[i] = $urandom;
                end
            end
            @(negedge clk);
        end
        total++;
        if (sum_in !== sum_out) begin
            bad++;
            $display("FAIL rnd_sum: got out=%0d want in=%0d", sum_out, sum_in);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (q[i].size() != 0) begin
                bad++;
                $display("FAIL rnd_lost[%0d]: got %0d pending want 0", i, q[i].size());
            end
        end
        total++;
        if (maxw > BOUND) begin
            bad++;
            $display("FAIL rnd_starve: got wait %0d want <= %0d", maxw, BOUND);
        end
    endtask

    initial begin
        en = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) word[i] = '0;
        drive();
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_early_drop();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
